cordic_rotator: RTL and testbench

CORDIC_ROTATOR -- requirements
Module: cordic_rotator

---
 rtl/cordic_pkg.sv | 44 ++++
 rtl/cordic_atan_rom.sv | 26 ++
 rtl/cordic_rotator.sv | 148 ++++++++++++++
 tb/tb_cordic_rotator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the CORDIC rotator.
// Constants are stored as signed Q2.30 words and are rescaled to the
// instantiated word width with scale_q (widths up to 64 bits).
package cordic_pkg;

   localparam int Q_INT_BITS   = 2;
   localparam int Q_FRAC_BITS  = 30;
   localparam int CONST_WIDTH  = Q_INT_BITS + Q_FRAC_BITS;
   localparam int ATAN_ENTRIES = 32;

   // Reciprocal CORDIC gain, 1/prod(sqrt(1+2^-2i)) ~= 0.607252935
   localparam logic [CONST_WIDTH-1:0] CORDIC_K = 32'h26DD3B6A;

   // atan(2^-i) in Q2.30 for i = 0..31
   localparam logic [CONST_WIDTH-1:0] ATAN_TABLE [ATAN_ENTRIES] = '{
      32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
      32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
      32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
      32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
      32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
      32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
      32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
      32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
   };

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ITER,
      FINISH
   } state_t;

   // Rescale a Q2.30 constant to Q2.(width-2); narrower words truncate.
   function automatic logic [63:0] scale_q(input logic [CONST_WIDTH-1:0] value,
                                           input int width);
      logic [63:0] wide;
      wide = {32'h0, value};
      if (width >= CONST_WIDTH) begin
         return wide << (width - CONST_WIDTH);
      end
      return wide >> (CONST_WIDTH - width);
   endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational lookup of atan(2^-idx) in Q2.(DATA_WIDTH-2).
// Entries come from cordic_pkg; past the table end atan(2^-i) equals 2^-i
// to well under one LSB, so those steps use a single set bit.
module cordic_atan_rom #(
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = 5
) (
   input  logic [IDX_W-1:0]      idx,
   output logic [DATA_WIDTH-1:0] atan_val
);
   import cordic_pkg::*;

   logic [4:0] tab_idx;

   // Select the table entry, or the small-angle approximation for deep steps
   always_comb begin
      tab_idx  = 5'(idx);
      atan_val = '0;
      if (int'(idx) < ATAN_ENTRIES) begin
         atan_val = DATA_WIDTH'(scale_q(ATAN_TABLE[tab_idx], DATA_WIDTH));
      end else if (int'(idx) <= DATA_WIDTH - 2) begin
         atan_val = DATA_WIDTH'(1) << (DATA_WIDTH - 2 - int'(idx));
      end
   end

endmodule

// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC producing cos/sin of a
// Q2.(DATA_WIDTH-2) angle, one micro-rotation per enabled clock.
// Build option: define CORDIC_ROUND_EN to round each shifted term half-up
// instead of truncating; timing and interface are the same either way.
module cordic_rotator #(
   parameter int DATA_WIDTH = 32,
   parameter int ITERATIONS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] angle,
   input  logic                  sign,
   output logic [DATA_WIDTH-1:0] cos_out,
   output logic [DATA_WIDTH-1:0] sin_out,
   output logic                  busy,
   output logic                  done
);
   import cordic_pkg::*;

   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERATIONS - 1);
   localparam logic signed [DATA_WIDTH-1:0] K_VAL =
      DATA_WIDTH'(scale_q(CORDIC_K, DATA_WIDTH));

   state_t state;
   state_t next_state;

   logic signed [DATA_WIDTH-1:0] x;
   logic signed [DATA_WIDTH-1:0] y;
   logic signed [DATA_WIDTH-1:0] z;
   logic signed [DATA_WIDTH-1:0] angle_q;
   logic                         sign_q;
   logic                         done_q;
   logic [IDX_W-1:0]             i;

   logic [DATA_WIDTH-1:0]        atan_raw;
   logic signed [DATA_WIDTH-1:0] atan_val;
   logic signed [DATA_WIDTH-1:0] x_shift;
   logic signed [DATA_WIDTH-1:0] y_shift;
   logic signed [DATA_WIDTH-1:0] x_next;
   logic signed [DATA_WIDTH-1:0] y_next;
   logic signed [DATA_WIDTH-1:0] z_next;

   cordic_atan_rom #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_atan_rom (
      .idx      (i),
      .atan_val (atan_raw)
   );

   assign atan_val = $signed(atan_raw);
   assign busy     = (state != IDLE);
   assign done     = done_q & clk_en;

   // State register; everything freezes while clk_en is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (clk_en) begin
         state <= next_state;
      end
   end

   // Sequencing: accept in IDLE, one LOAD cycle, ITERATIONS steps, one FINISH
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = LOAD;
         LOAD:    next_state = ITER;
         ITER:    if (i == LAST_IDX) next_state = FINISH;
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Shifted cross terms, optionally rounded by the first bit shifted out
   always_comb begin
      x_shift = x >>> i;
      y_shift = y >>> i;
`ifdef CORDIC_ROUND_EN
      if (i != '0) begin
         x_shift = x_shift + $signed({{(DATA_WIDTH-1){1'b0}}, x[i - IDX_W'(1)]});
         y_shift = y_shift + $signed({{(DATA_WIDTH-1){1'b0}}, y[i - IDX_W'(1)]});
      end
`endif
   end

   // One micro-rotation steering z toward zero; wraps at DATA_WIDTH
   always_comb begin
      if (!z[DATA_WIDTH-1]) begin
         x_next = x - y_shift;
         y_next = y + x_shift;
         z_next = z - atan_val;
      end else begin
         x_next = x + y_shift;
         y_next = y - x_shift;
         z_next = z + atan_val;
      end
   end

   // Datapath and result registers, advanced only on enabled cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x       <= '0;
         y       <= '0;
         z       <= '0;
         i       <= '0;
         angle_q <= '0;
         sign_q  <= 1'b0;
         cos_out <= '0;
         sin_out <= '0;
         done_q  <= 1'b0;
      end else if (clk_en) begin
         done_q <= (state == FINISH);
         case (state)
            IDLE: begin
               if (start) begin
                  angle_q <= angle;
                  sign_q  <= sign;
               end
            end
            LOAD: begin
               x <= K_VAL;
               y <= '0;
               z <= angle_q;
               i <= '0;
            end
            ITER: begin
               x <= x_next;
               y <= y_next;
               z <= z_next;
               i <= i + 1'b1;
            end
            FINISH: begin
               cos_out <= sign_q ? x : -x;
               sin_out <= sign_q ? y : -y;
            end
            default: begin
               x <= x;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: self-checking bench comparing cordic_rotator against a
// real-number cos/sin model, with directed timing cases and random angles.
`timescale 1ns/1ps
module tb_cordic_rotator;

   localparam int          DW       = 32;
   localparam int          ITER_N   = 16;
   localparam int          LATENCY  = ITER_N + 2;
   localparam real         SCALE    = 1073741824.0;
   localparam longint      DIR_TOL  = 40000;
   localparam longint      RAND_TOL = 65536;
   localparam logic [31:0] PI_4     = 32'h3243F6A9;
   localparam logic [31:0] PI_8     = 32'h1921FB54;
   localparam longint      HALF_PI  = 1686629713;

   logic          clk = 1'b0;
   logic          rst;
   logic          clk_en;
   logic          start;
   logic          sign;
   logic          busy;
   logic          done;
   logic [DW-1:0] angle;
   logic [DW-1:0] cos_out;
   logic [DW-1:0] sin_out;

   int checks = 0;
   int errors = 0;

   cordic_rotator #(
      .DATA_WIDTH (DW),
      .ITERATIONS (ITER_N)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .start   (start),
      .angle   (angle),
      .sign    (sign),
      .cos_out (cos_out),
      .sin_out (sin_out),
      .busy    (busy),
      .done    (done)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Hard stop in case a wait logic error ever leaves the bench stuck
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input longint observed,
                              input longint expected, input longint tol);
      longint diff;
      checks++;
      diff = observed - expected;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d (tolerance %0d)",
                  tag, observed, expected, tol);
      end
   endtask

   // Ideal rotation: cos/sin of the angle, negated when the angle was folded
   function automatic void refModel(input logic [31:0] ang, input logic sgn,
                                    output longint exp_cos, output longint exp_sin);
      real theta;
      real c;
      real s;
      theta = real'($signed(ang)) / SCALE;
      c = $cos(theta) * SCALE;
      s = $sin(theta) * SCALE;
      if (!sgn) begin
         c = -c;
         s = -s;
      end
      exp_cos = longint'(c);
      exp_sin = longint'(s);
   endfunction

   task automatic checkResult(input string tag, input logic [31:0] ang,
                              input logic sgn, input longint tol);
      longint exp_cos;
      longint exp_sin;
      refModel(ang, sgn, exp_cos, exp_sin);
      checkOutput({tag, "_cos"}, longint'($signed(cos_out)), exp_cos, tol);
      checkOutput({tag, "_sin"}, longint'($signed(sin_out)), exp_sin, tol);
   endtask

   // Count clock edges after an accept edge until done is seen (bounded)
   task automatic waitDone(input int stall_at, input int retrig_at,
                           input logic hold_start, output int cycles);
      cycles = 0;
      while (cycles < 100) begin
         clk_en = !(stall_at >= 0 && cycles >= stall_at && cycles < stall_at + 4);
         start  = hold_start || (cycles == retrig_at);
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (done) break;
      end
      clk_en = 1'b1;
      start  = hold_start;
   endtask

   task automatic applyStimulus(input logic [31:0] ang, input logic sgn,
                                input int stall_at, input int retrig_at,
                                output int cycles);
      @(negedge clk);
      angle  = ang;
      sign   = sgn;
      start  = 1'b1;
      clk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_accept", longint'(busy), 1, 0);
      angle = $urandom();
      sign  = 1'($urandom_range(0, 1));
      waitDone(stall_at, retrig_at, 1'b0, cycles);
   endtask

   initial begin
      int          cycles;
      int          dones;
      int          stall;
      int unsigned r;
      logic [31:0] ang;
      logic        sgn;

      rst    = 1'b1;
      clk_en = 1'b1;
      start  = 1'b0;
      angle  = '0;
      sign   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_cos", longint'($signed(cos_out)), 0, 0);
      checkOutput("reset_sin", longint'($signed(sin_out)), 0, 0);
      checkOutput("reset_busy", longint'(busy), 0, 0);
      checkOutput("reset_done", longint'(done), 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Zero angle: latency, result, busy drop and single-cycle done
      applyStimulus(32'h0, 1'b1, -1, -1, cycles);
      checkOutput("lat_zero", cycles, LATENCY, 0);
      checkResult("zero", 32'h0, 1'b1, DIR_TOL);
      checkOutput("busy_at_done", longint'(busy), 0, 0);
      @(negedge clk);
      checkOutput("done_single", longint'(done), 0, 0);

      // pi/4 unfolded and folded
      applyStimulus(PI_4, 1'b1, -1, -1, cycles);
      checkOutput("lat_pi4", cycles, LATENCY, 0);
      checkResult("pi4_pos", PI_4, 1'b1, DIR_TOL);
      applyStimulus(PI_4, 1'b0, -1, -1, cycles);
      checkOutput("lat_pi4_neg", cycles, LATENCY, 0);
      checkResult("pi4_neg", PI_4, 1'b0, DIR_TOL);

      // Results hold while idle
      repeat (5) @(negedge clk);
      checkResult("hold", PI_4, 1'b0, DIR_TOL);

      // Retrigger while busy is ignored, four-cycle stall stretches latency
      applyStimulus(PI_4, 1'b1, 6, 2, cycles);
      checkOutput("lat_stall", cycles, LATENCY + 4, 0);
      checkResult("stall", PI_4, 1'b1, DIR_TOL);

      // Reset in the middle of ITER
      @(negedge clk);
      angle = PI_8;
      sign  = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_cos", longint'($signed(cos_out)), 0, 0);
      checkOutput("midrst_sin", longint'($signed(sin_out)), 0, 0);
      checkOutput("midrst_busy", longint'(busy), 0, 0);
      checkOutput("midrst_done", longint'(done), 0, 0);
      dones = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) dones++;
      end
      rst = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done) dones++;
      end
      checkOutput("midrst_no_done", dones, 0, 0);
      checkOutput("midrst_cos_idle", longint'($signed(cos_out)), 0, 0);
      applyStimulus(PI_8, 1'b1, -1, -1, cycles);
      checkOutput("lat_after_rst", cycles, LATENCY, 0);
      checkResult("after_rst", PI_8, 1'b1, DIR_TOL);

      // start held high: back-to-back computations every ITERATIONS+3 cycles
      @(negedge clk);
      angle = PI_8;
      sign  = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      angle = PI_4;
      sign  = 1'b1;
      waitDone(-1, -1, 1'b1, cycles);
      checkOutput("lat_b2b_first", cycles, LATENCY, 0);
      checkResult("b2b_first", PI_8, 1'b0, DIR_TOL);
      waitDone(-1, -1, 1'b1, cycles);
      start = 1'b0;
      checkOutput("lat_b2b_second", cycles, ITER_N + 3, 0);
      checkResult("b2b_second", PI_4, 1'b1, DIR_TOL);

      // Random legal angles, some with a clock-enable stall
      for (int n = 0; n < 1000; n++) begin
         r     = $urandom_range(32'd3373259426, 32'd0);
         ang   = 32'(longint'(r) - HALF_PI);
         sgn   = 1'($urandom_range(1, 0));
         stall = (n % 7 == 0) ? int'($urandom_range(12, 2)) : -1;
         applyStimulus(ang, sgn, stall, -1, cycles);
         checkOutput("rand_lat", cycles, (stall >= 0) ? LATENCY + 4 : LATENCY, 0);
         checkResult("rand", ang, sgn, RAND_TOL);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
